// File: rtl/banana_core.sv
// banana_core: 16-register multi-cycle load/store core with a single shared memory port.
// Six-state FSM (fetch/decode/exec/mem/wb/halt) with registered memory-side outputs.
module banana_core #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [3:0]       psr_flags,
  output logic             halted,
  output logic [WIDTH-1:0] pc_out
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q, a_q, b_q, mdr_q, res_q;
  logic [15:0]      ir_q;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] rf_q [16];

  logic [3:0]       op, rd, ext, rs, fn;
  logic [WIDTH-1:0] imm, alu_res, exec_pc;
  logic [WIDTH:0]   sum, dif;
  logic [3:0]       alu_flags;
  logic             is_alu, is_load, is_stor, is_jc, is_bc, use_imm, taken;

  always_comb begin
    op  = ir_q[15:12];
    rd  = ir_q[11:8];
    ext = ir_q[7:4];
    rs  = ir_q[3:0];
    imm = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
    // R-type and immediate forms share one function encoding
    fn  = (op == 4'h0) ? ext : op;
    is_alu  = ((op == 4'h0) && (fn inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD})) ||
              (op inside {4'h5, 4'h9, 4'hB, 4'hD});
    is_load = (op == 4'h4) && (ext == 4'h0);
    is_stor = (op == 4'h4) && (ext == 4'h4);
    is_jc   = (op == 4'h4) && (ext == 4'hC);
    is_bc   = (op == 4'hC);
    use_imm = op inside {4'h5, 4'h9, 4'hB, 4'hD, 4'hC};
  end

  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    dif       = {1'b0, a_q} - {1'b0, b_q};
    alu_res   = b_q;
    alu_flags = flags_q;
    case (fn)
      4'h5: begin
        alu_res   = sum[WIDTH-1:0];
        alu_flags = {alu_res[WIDTH-1], sum[WIDTH],
                     (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]),
                     alu_res == '0};
      end
      4'h9, 4'hB: begin
        alu_res   = dif[WIDTH-1:0];
        alu_flags = {alu_res[WIDTH-1], dif[WIDTH],
                     (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]),
                     alu_res == '0};
      end
      4'h1, 4'h2, 4'h3: begin
        if (fn == 4'h1)      alu_res = a_q & b_q;
        else if (fn == 4'h2) alu_res = a_q | b_q;
        else                 alu_res = a_q ^ b_q;
        alu_flags = {alu_res[WIDTH-1], flags_q[2], flags_q[1], alu_res == '0};
      end
      default: alu_res = b_q;
    endcase

    case (rd)
      4'h0:    taken = flags_q[0];
      4'h1:    taken = !flags_q[0];
      4'hE:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
    // pc_q already points past the branch, so step back one for the base
    exec_pc = pc_q;
    if ((is_bc || is_jc) && taken) exec_pc = is_bc ? (pc_q - WIDTH'(1) + b_q) : b_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      pc_q      <= WIDTH'(RESET_PC);
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mdr_q     <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      halted    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (mem_req && mem_ready) begin
            ir_q    <= mem_rdata[15:0];
            pc_q    <= pc_q + WIDTH'(1);
            mem_req <= 1'b0;
            state_q <= StDecode;
          end else if (!mem_req) begin
            // only reached right after reset; later entries arrive with the request raised
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc_q;
          end
        end
        StDecode: begin
          a_q <= rf_q[rd];
          b_q <= use_imm ? imm : rf_q[rs];
          if (is_load || is_stor) begin
            mem_req   <= 1'b1;
            mem_we    <= is_stor;
            mem_addr  <= rf_q[rs];
            mem_wdata <= rf_q[rd];
            state_q   <= StMem;
          end else if (is_alu || is_jc || is_bc) begin
            state_q <= StExec;
          end else begin
            halted  <= 1'b1;
            state_q <= StHalt;
          end
        end
        StExec: begin
          if (is_alu) flags_q <= alu_flags;
          if (is_alu && (fn != 4'hB)) begin
            res_q   <= alu_res;
            state_q <= StWb;
          end else begin
            pc_q     <= exec_pc;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= exec_pc;
            state_q  <= StFetch;
          end
        end
        StMem: begin
          if (mem_ready) begin
            mem_we <= 1'b0;
            if (is_load) begin
              mdr_q   <= mem_rdata;
              mem_req <= 1'b0;
              state_q <= StWb;
            end else begin
              mem_addr <= pc_q;
              state_q  <= StFetch;
            end
          end
        end
        StWb: begin
          rf_q[rd] <= is_load ? mdr_q : res_q;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc_q;
          state_q  <= StFetch;
        end
        StHalt: begin
          halted  <= 1'b1;
          mem_req <= 1'b0;
        end
        default: state_q <= StHalt;
      endcase
    end
  end

  assign psr_flags = flags_q;
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_banana_core.sv
// Directed bench for banana_core: ALU/flags, stalled store + load, branches/jumps, halt and reset.
module tb_banana_core;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         mem_req, mem_we, mem_ready, halted;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [3:0]   psr_flags;

  logic [15:0]  prog [256];
  logic         st_valid = 1'b0;
  logic [W-1:0] st_addr = '0;
  logic [W-1:0] st_data = '0;
  int           n_pass = 0;
  int           n_total = 0;

  banana_core #(.WIDTH(W), .RESET_PC(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .psr_flags (psr_flags),
    .halted    (halted),
    .pc_out    (pc_out)
  );

  always #5 clk = ~clk;

  // Program ROM plus a one-entry data store that returns the last write
  assign mem_rdata = (st_valid && (mem_addr == st_addr)) ? st_data : prog[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) begin
      st_valid <= 1'b1;
      st_addr  <= mem_addr;
      st_data  <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
  endtask

  initial begin
    // ---------------- ALU and flags ----------------
    mem_ready = 1'b1;
    clear_prog();
    prog[0]  = 16'hD105;                            // MOVI r1,5
    prog[1]  = 16'hD2FD;                            // MOVI r2,-3
    prog[2]  = 16'h0152;                            // ADD r1,r2
    prog[3]  = 16'hD340;                            // MOVI r3,0x40
    for (int i = 4; i <= 12; i++) prog[i] = 16'h0353; // ADD r3,r3
    prog[13] = 16'h9301;                            // SUBI r3,1
    prog[14] = 16'h5301;                            // ADDI r3,1
    prog[15] = 16'h0333;                            // XOR r3,r3
    prog[16] = 16'h06D1;                            // MOV r6,r1
    step(3);
    check("rst_pc", pc_out, 0);
    check("rst_req", mem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_flags", psr_flags, 0);
    reset = 1'b1;
    step(1);
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 0);
    step(3);
    check("movi_mid_req", mem_req, 0);
    step(1);
    check("movi_lat_addr", mem_addr, 1);
    check("movi_r1", dut.rf_q[1], 5);
    step(8);
    check("add_addr", mem_addr, 3);
    check("add_r1", dut.rf_q[1], 2);
    check("add_flags", psr_flags, 4'b0100);
    step(40);
    check("dbl_addr", mem_addr, 13);
    check("dbl_r3", dut.rf_q[3], 16'h8000);
    check("dbl_flags", psr_flags, 4'b1010);
    step(4);
    check("subi_r3", dut.rf_q[3], 16'h7FFF);
    check("subi_flags", psr_flags, 4'b0010);
    step(4);
    check("addi_r3", dut.rf_q[3], 16'h8000);
    check("addi_flags", psr_flags, 4'b1010);
    step(4);
    check("xor_r3", dut.rf_q[3], 0);
    check("xor_flags", psr_flags, 4'b0011);
    step(4);
    check("mov_r6", dut.rf_q[6], 2);
    check("mov_flags", psr_flags, 4'b0011);
    check("mov_addr", mem_addr, 17);
    step(2);
    check("halt_set", halted, 1);
    check("halt_req", mem_req, 0);
    step(5);
    check("halt_hold", halted, 1);
    check("halt_req_hold", mem_req, 0);
    check("halt_pc", pc_out, 18);

    // ---------------- stalled store, then load ----------------
    reset = 1'b0;
    step(1);
    check("rst2_halted", halted, 0);
    check("rst2_flags", psr_flags, 0);
    check("rst2_r3", dut.rf_q[3], 0);
    clear_prog();
    prog[0] = 16'hD15A;                             // MOVI r1,0x5A
    prog[1] = 16'hD420;                             // MOVI r4,0x20
    prog[2] = 16'h4144;                             // STOR r1,[r4]
    prog[3] = 16'h4504;                             // LOAD r5,[r4]
    reset = 1'b1;
    step(1);
    check("rst2_fetch_addr", mem_addr, 0);
    step(8);
    check("stor_fetch_addr", mem_addr, 2);
    step(1);
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) step(1);
      else step(1);
      check("stor_req", mem_req, 1);
      check("stor_we", mem_we, 1);
      check("stor_addr", mem_addr, 16'h0020);
      check("stor_wdata", mem_wdata, 16'h005A);
    end
    mem_ready = 1'b1;
    step(1);
    check("stor_done_addr", mem_addr, 3);
    check("stor_done_we", mem_we, 0);
    check("stor_mem_addr", st_addr, 16'h0020);
    check("stor_mem_data", st_data, 16'h005A);
    step(4);
    check("load_r5", dut.rf_q[5], 16'h005A);
    check("load_next_addr", mem_addr, 4);

    // ---------------- jump and conditional branches ----------------
    reset = 1'b0;
    step(1);
    clear_prog();
    prog[0]  = 16'hD70F;                            // MOVI r7,0x0F
    prog[1]  = 16'h4EC7;                            // JCOND always,r7
    prog[14] = 16'hD233;                            // MOVI r2,0x33
    prog[15] = 16'h01B1;                            // CMP r1,r1
    prog[16] = 16'hC0FE;                            // BCOND EQ,-2
    reset = 1'b1;
    step(1);
    check("br_first_addr", mem_addr, 0);
    step(4);
    step(3);
    check("jcond_addr", mem_addr, 16'h000F);
    step(3);
    check("cmp_addr", mem_addr, 16'h0010);
    check("cmp_flags", psr_flags, 4'b0001);
    check("cmp_r1", dut.rf_q[1], 0);
    step(3);
    check("beq_taken_addr", mem_addr, 16'h000E);
    check("beq_taken_pc", pc_out, 16'h000E);
    prog[16] = 16'hC1FE;                            // BCOND NE,-2
    step(4);
    check("movi2_addr", mem_addr, 16'h000F);
    check("movi2_r2", dut.rf_q[2], 16'h0033);
    step(6);
    check("bne_not_taken_addr", mem_addr, 16'h0011);
    step(2);
    check("final_halt", halted, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
